// File: rtl/maxnet_pkg.sv
// Shared types, defaults and helpers for the Maxnet winner detector.
// State encodings are plain constants so older tools can consume them.
package maxnet_pkg;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_LABEL_W  = 32;
  localparam int DEF_MAX_ITER = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Zero test ignores the MSB (sign), so -0 counts as zero.
  function automatic logic is_zero(input logic [63:0] w, input int w_bits);
    logic [63:0] mask;
    mask = (64'd1 << (w_bits - 1)) - 64'd1;
    return (w & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/maxnet_nz_scan.sv
// Combinational scan of one activation sample: zero flags,
// exactly-one / none summaries, highest nonzero index and its label.
module maxnet_nz_scan
  import maxnet_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LABEL_W = DEF_LABEL_W
) (
  input  logic [N_CH*DATA_W-1:0]  x,
  input  logic [N_CH*LABEL_W-1:0] a,
  output logic                    nz_one,
  output logic                    nz_none,
  output logic [$clog2(N_CH)-1:0] hi_idx,
  output logic [LABEL_W-1:0]      hi_label
);

  localparam int IDX_W = $clog2(N_CH);

  logic [N_CH-1:0] zero;
  logic            seen;
  logic            multi;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      zero[k] = is_zero(64'(x[k*DATA_W +: DATA_W]), DATA_W);
    end
  end

  // Ascending scan leaves the highest nonzero channel in hi_idx.
  always_comb begin
    seen     = 1'b0;
    multi    = 1'b0;
    hi_idx   = '0;
    hi_label = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!zero[k]) begin
        if (seen) multi = 1'b1;
        seen     = 1'b1;
        hi_idx   = IDX_W'(k);
        hi_label = a[k*LABEL_W +: LABEL_W];
      end
    end
    nz_none = !seen;
    nz_one  = seen && !multi;
  end

endmodule

// File: rtl/maxnet_winner_detect.sv
// Maxnet termination detector: tracks iterations and reports
// winner / collapse / timeout with the last candidate channel.
module maxnet_winner_detect
  import maxnet_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LABEL_W  = DEF_LABEL_W,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [N_CH*DATA_W-1:0]         x,
  input  logic [N_CH*LABEL_W-1:0]        a,
  output logic                           busy,
  output logic                           done,
  output logic                           winner_valid,
  output logic                           no_winner,
  output logic                           timeout,
  output logic [$clog2(N_CH)-1:0]        winner_idx,
  output logic [LABEL_W-1:0]             winner_label,
  output logic [$clog2(MAX_ITER+1)-1:0]  iter_count
);

  localparam int IDX_W  = $clog2(N_CH);
  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

  state_t               state_q, state_d;
  logic [ITER_W-1:0]    iter_q, iter_d;
  logic                 win_q, win_d;
  logic                 none_q, none_d;
  logic                 tmo_q, tmo_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LABEL_W-1:0]   label_q, label_d;

  logic                 nz_one;
  logic                 nz_none;
  logic [IDX_W-1:0]     hi_idx;
  logic [LABEL_W-1:0]   hi_label;

  maxnet_nz_scan #(
    .N_CH    (N_CH),
    .DATA_W  (DATA_W),
    .LABEL_W (LABEL_W)
  ) u_scan (
    .x        (x),
    .a        (a),
    .nz_one   (nz_one),
    .nz_none  (nz_none),
    .hi_idx   (hi_idx),
    .hi_label (hi_label)
  );

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    win_d   = win_q;
    none_d  = none_q;
    tmo_d   = tmo_q;
    idx_d   = idx_q;
    label_d = label_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start) begin
          state_d = ST_RUN;
          iter_d  = '0;
          win_d   = 1'b0;
          none_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      (state_q == ST_RUN): begin
        if (in_valid) begin
          iter_d = iter_q + ITER_W'(1);
          // A collapse keeps the candidate from the previous sample.
          if (!nz_none) begin
            idx_d   = hi_idx;
            label_d = hi_label;
          end
          if (nz_one) begin
            win_d   = 1'b1;
            state_d = ST_DONE;
          end else if (nz_none) begin
            none_d  = 1'b1;
            state_d = ST_DONE;
          end else if (iter_q == LAST_ITER) begin
            tmo_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      (state_q == ST_DONE): begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      win_q   <= 1'b0;
      none_q  <= 1'b0;
      tmo_q   <= 1'b0;
      idx_q   <= '0;
      label_q <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      win_q   <= win_d;
      none_q  <= none_d;
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      label_q <= label_d;
    end
  end

  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign winner_valid = win_q;
  assign no_winner    = none_q;
  assign timeout      = tmo_q;
  assign winner_idx   = idx_q;
  assign winner_label = label_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_winner_detect.sv
// Bench for maxnet_winner_detect: search-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_maxnet_winner_detect;

  localparam int N_CH     = 4;
  localparam int DATA_W   = 32;
  localparam int LABEL_W  = 32;
  localparam int MAX_ITER = 4;
  localparam int ITER_W   = $clog2(MAX_ITER + 1);
  localparam int IDX_W    = $clog2(N_CH);

  localparam logic [31:0] F0  = 32'h0000_0000;
  localparam logic [31:0] FN0 = 32'h8000_0000;
  localparam logic [31:0] F1  = 32'h3f80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] F5  = 32'h40a0_0000;
  localparam logic [31:0] FM1 = 32'hbf80_0000;

  logic                       clk;
  logic                       rst_n;
  logic                       start;
  logic                       in_valid;
  logic [N_CH*DATA_W-1:0]     x;
  logic [N_CH*LABEL_W-1:0]    a;
  logic                       busy;
  logic                       done;
  logic                       winner_valid;
  logic                       no_winner;
  logic                       timeout;
  logic [IDX_W-1:0]           winner_idx;
  logic [LABEL_W-1:0]         winner_label;
  logic [ITER_W-1:0]          iter_count;

  int n_chk  = 0;
  int n_fail = 0;

  maxnet_winner_detect #(
    .N_CH     (N_CH),
    .DATA_W   (DATA_W),
    .LABEL_W  (LABEL_W),
    .MAX_ITER (MAX_ITER)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .x            (x),
    .a            (a),
    .busy         (busy),
    .done         (done),
    .winner_valid (winner_valid),
    .no_winner    (no_winner),
    .timeout      (timeout),
    .winner_idx   (winner_idx),
    .winner_label (winner_label),
    .iter_count   (iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Search-level model: a search is a sequence of samples; it ends on
  // the first sample with one or zero nonzero channels, or on the
  // MAX_ITER-th sample. Done is reported for one cycle afterwards.
  logic               m_in_search;
  logic               m_done;
  logic               m_win;
  logic               m_none;
  logic               m_tmo;
  int                 m_idx;
  logic [LABEL_W-1:0] m_label;
  int                 m_iter;

  task automatic model_reset();
    m_in_search = 1'b0;
    m_done      = 1'b0;
    m_win       = 1'b0;
    m_none      = 1'b0;
    m_tmo       = 1'b0;
    m_idx       = 0;
    m_label     = '0;
    m_iter      = 0;
  endtask

  task automatic model_sample();
    int          cnt;
    int          hi;
    logic [31:0] w;
    cnt = 0;
    hi  = -1;
    for (int k = 0; k < N_CH; k++) begin
      w = x[k*DATA_W +: DATA_W];
      if ((w & 32'h7fff_ffff) != 0) begin
        cnt++;
        hi = k;
      end
    end
    m_iter++;
    if (cnt >= 1) begin
      m_idx   = hi;
      m_label = a[hi*LABEL_W +: LABEL_W];
    end
    if (cnt == 1) m_win = 1'b1;
    else if (cnt == 0) m_none = 1'b1;
    else if (m_iter == MAX_ITER) m_tmo = 1'b1;
    if (m_win || m_none || m_tmo) begin
      m_in_search = 1'b0;
      m_done      = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (!m_in_search) begin
        if (start) begin
          m_in_search = 1'b1;
          m_iter      = 0;
          m_win       = 1'b0;
          m_none      = 1'b0;
          m_tmo       = 1'b0;
        end
      end else if (in_valid) begin
        model_sample();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc_busy",  64'(busy),         64'(m_in_search));
        chk("cyc_done",  64'(done),         64'(m_done));
        chk("cyc_win",   64'(winner_valid), 64'(m_win));
        chk("cyc_none",  64'(no_winner),    64'(m_none));
        chk("cyc_tmo",   64'(timeout),      64'(m_tmo));
        chk("cyc_idx",   64'(winner_idx),   64'(m_idx));
        chk("cyc_label", 64'(winner_label), 64'(m_label));
        chk("cyc_iter",  64'(iter_count),   64'(m_iter));
      end
    end
  end

  function automatic logic [N_CH*DATA_W-1:0] px(
    input logic [31:0] c0, input logic [31:0] c1,
    input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [N_CH*LABEL_W-1:0] lbl(input int base);
    return {32'(base + 3), 32'(base + 2), 32'(base + 1), 32'(base)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic sample(input logic [N_CH*DATA_W-1:0] xv,
                        input logic [N_CH*LABEL_W-1:0] av);
    in_valid = 1'b1;
    x        = xv;
    a        = av;
    cyc();
    in_valid = 1'b0;
    x        = '0;
  endtask

  task automatic chk_result(input string nm, input logic w, input logic n,
                            input logic t, input int idx, input int label,
                            input int iter);
    chk({nm, "_done"},  64'(done),         64'd1);
    chk({nm, "_busy"},  64'(busy),         64'd0);
    chk({nm, "_win"},   64'(winner_valid), 64'(w));
    chk({nm, "_none"},  64'(no_winner),    64'(n));
    chk({nm, "_tmo"},   64'(timeout),      64'(t));
    chk({nm, "_idx"},   64'(winner_idx),   64'(idx));
    chk({nm, "_label"}, 64'(winner_label), 64'(label));
    chk({nm, "_iter"},  64'(iter_count),   64'(iter));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},  64'(busy),         64'd0);
    chk({nm, "_done"},  64'(done),         64'd0);
    chk({nm, "_win"},   64'(winner_valid), 64'd0);
    chk({nm, "_none"},  64'(no_winner),    64'd0);
    chk({nm, "_tmo"},   64'(timeout),      64'd0);
    chk({nm, "_idx"},   64'(winner_idx),   64'd0);
    chk({nm, "_label"}, 64'(winner_label), 64'd0);
    chk({nm, "_iter"},  64'(iter_count),   64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    a        = '0;
    #12;
    chk_all_zero("rst");
    rst_n = 1'b1;
    cyc();

    // Single winner at ch2; a start during DONE must be ignored.
    do_start();
    chk("t2_busy", 64'(busy), 64'd1);
    sample(px(F0, F0, F3, F0), lbl(10));
    chk_result("t2", 1'b1, 1'b0, 1'b0, 2, 12, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t2_done_start_busy", 64'(busy), 64'd0);
    chk("t2_done_start_done", 64'(done), 64'd0);
    cyc();

    // Convergence 4 -> 3 -> 2 -> 1 nonzero, with a stall.
    do_start();
    chk("t3_clear_win", 64'(winner_valid), 64'd0);
    sample(px(F1, F2, F3, F5), lbl(10));
    sample(px(F1, F2, FM1, F0), lbl(10));
    cyc();
    sample(px(F0, F2, F0, F1), lbl(10));
    sample(px(F0, F1, F0, F0), lbl(10));
    chk_result("t3", 1'b1, 1'b0, 1'b0, 1, 11, 4);
    cyc();
    cyc();

    // Collapse: candidate carried from the previous sample; -0 is zero.
    do_start();
    sample(px(F0, F2, F5, F0), lbl(10));
    sample(px(FN0, F0, F0, F0), lbl(40));
    chk_result("t4", 1'b0, 1'b1, 1'b0, 2, 12, 2);
    cyc();

    // Timeout after MAX_ITER samples with ch0 and ch3 nonzero.
    do_start();
    for (int i = 0; i < MAX_ITER; i++) begin
      sample(px(F1, F0, F0, F2), lbl(20));
    end
    chk_result("t5", 1'b0, 1'b0, 1'b1, 3, 23, 4);
    cyc();
    chk("t5_hold_tmo", 64'(timeout), 64'd1);
    chk("t5_hold_iter", 64'(iter_count), 64'd4);

    // Stalls, start in RUN, then an async reset mid-search.
    do_start();
    cyc();
    cyc();
    chk("t6_stall_iter", 64'(iter_count), 64'd0);
    chk("t6_stall_busy", 64'(busy), 64'd1);
    sample(px(F1, F1, F0, F0), lbl(30));
    do_start();
    chk("t6_rs_busy", 64'(busy), 64'd1);
    chk("t6_rs_iter", 64'(iter_count), 64'd1);
    chk("t6_rs_idx", 64'(winner_idx), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_abort");
    cyc();
    chk("t6_no_done", 64'(done), 64'd0);
    #3;
    rst_n = 1'b1;
    cyc();
    chk("t6_post_done", 64'(done), 64'd0);
    chk("t6_post_busy", 64'(busy), 64'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
